numero_display: RTL
===================

# numero_display

Sequential binary-to-decimal display driver: accepts a binary value (0–9999) with a start/done handshake and converts it to four BCD digits using iterative shift-add-3 (double dabble), one bit per clock. It drives four active-low seven-segment displays with optional leading-zero blanking. It is the output-side counterpart of the keypad entry path: the keypad produces a number, and this block renders a number computed elsewhere back onto HEX3..HEX0.

## Interface
- WIDTH, 14: input value width. Legal range 4..14.
- BLANK_LZ, 1: 1 blanks leading zero digits. HEX0 is never blanked.
- clk  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  request conversion of `value`; sampled only in IDLE
- value  in  WIDTH  unsigned binary value to display
- busy  out  1  high while a conversion is in progress
- done  out  1  one-cycle pulse when new digits are valid
- overflow  out  1  captured value exceeded 9999; held until next accepted start
- bcd3, bcd2, bcd1, bcd0  out  4 each  registered BCD digits (thousands..units)
- HEX3, HEX2, HEX1, HEX0  out  [0:6] each  segments a..g, active-low

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1:
  - Capture `value` into the shift register.
  - If value > 9999, capture 9999 and set overflow=1; otherwise clear overflow.
  - Clear the 16-bit BCD accumulator, load bit counter = WIDTH, go to SHIFT.
- SHIFT, each cycle:
  - For each accumulator nibble ≥5, add 3 (all four nibbles corrected in parallel from pre-step values).
  - Shift {accumulator, shift register} left by 1 and decrement the counter.
  - When the counter reaches 0 after the step, go to DONE.
- DONE, one cycle:
  - Copy accumulator to bcd3..bcd0.
  - Register HEX outputs from the new digits, pulse done, go to IDLE.
- Output hold: bcd*/HEX* change only on the DONE transition. They hold previous values during conversion, so the display never shows intermediate values.
- Leading-zero blanking (BLANK_LZ=1): a digit is blank (1111111) when it and all higher digits are 0. HEX0 always shows its digit.
- Segment encoding, active-low, a..g:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - Non-BCD codes (unreachable) display blank.
- start while busy is ignored; `value` changes while busy have no effect.

## Timing
- Start accepted at edge E0. busy=1 from E0.
- SHIFT steps at E1..E_WIDTH.
- DONE is entered after E_WIDTH. At E_(WIDTH+1): outputs update, done=1 for one cycle, busy=0.
- Latency start→done: WIDTH+1 cycles (15 at default).
- start asserted in the cycle done=1 is accepted (FSM already in IDLE); back-to-back throughput is one conversion per WIDTH+2 cycles.
- Reset values:
  - FSM=IDLE, busy=0, done=0, overflow=0, bcd*=0.
  - HEX0=0000001.
  - HEX3..HEX1=1111111 if BLANK_LZ, else 0000001.
- Reset mid-conversion aborts immediately to reset values; no done pulse.

## Structure
- Shared package `numero_pkg`:
  - MAX_VALUE=9999
  - SEG_BLANK=7'b1111111
  - state enum {IDLE, SHIFT, DONE}
  - digit-to-segment function or constant table, shared with the keypad path
- One sub-module is natural: `seg7_decoder` (4-bit BCD + blank in → [0:6] active-low out, combinational), instantiated four times. Its outputs are registered in the parent.
- Double-dabble datapath and FSM stay in the top module.

## Test plan
- Reset release, no start → all bcd=0, HEX0=0000001, HEX3..1=1111111 (BLANK_LZ=1), busy=0.
- start with value=1234 → done exactly 15 cycles after the start edge. bcd=1,2,3,4; HEX3..0 = 1001111, 0010010, 0000110, 1001100; overflow=0.
- value=7 then value=0 (BLANK_LZ=1) → HEX3..1 blank with HEX0=0001111, then HEX0=0000001 with others blank. Repeat with BLANK_LZ=0 → leading 0000001 on all digits.
- value=12000 → bcd=9,9,9,9, all HEX=0000100, overflow=1. Next start with value=5 → overflow=0.
- Start 4321, pulse start with 1111 at cycle 5 and change `value` → second start ignored; result 4321. Start asserted in the done cycle → second conversion accepted.
- Start 9876, assert reset at cycle 8 → immediate reset values, no done pulse. Following start with 42 → bcd=0,0,4,2.

Source files
------------

// File: rtl/numero_pkg.sv
// Shared definitions for the numeric display path: value limits, FSM states
// and the BCD digit to active-low seven-segment table (segments a..g).
package numero_pkg;

  localparam int         MAX_VALUE = 9999;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Active-low segment pattern for one BCD digit; non-BCD codes show blank.
  function automatic logic [0:6] seg_encode(input logic [3:0] digit);
    logic [0:6] seg;
    case (digit)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low seven-segment decoder with blank.
module seg7_decoder
  import numero_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [0:6] seg
);

  // Blank overrides the digit; otherwise look the digit up in the shared table.
  always_comb begin
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      seg = seg_encode(digit);
    end
  end

endmodule

// File: rtl/numero_display.sv
// Binary to four-digit BCD display driver. A start in IDLE captures the value
// (clipped to 9999), runs one double-dabble step per clock, then updates the
// registered digits and segment outputs together in a single DONE cycle.
module numero_display
  import numero_pkg::*;
#(
  parameter int WIDTH    = 14,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [3:0]       bcd3,
  output logic [3:0]       bcd2,
  output logic [3:0]       bcd1,
  output logic [3:0]       bcd0,
  output logic [0:6]       HEX3,
  output logic [0:6]       HEX2,
  output logic [0:6]       HEX1,
  output logic [0:6]       HEX0
);

  localparam int         CNT_W    = $clog2(WIDTH + 1);
  localparam logic [13:0] MAX_CODE = 14'(MAX_VALUE);

  state_t             state_r;
  logic [WIDTH-1:0]   shift_r;
  logic [15:0]        acc_r;
  logic [CNT_W-1:0]   cnt_r;

  logic [13:0]        value_ext_s;
  logic [13:0]        value_clip_s;
  logic               over_s;
  logic [15:0]        acc_adj_s;
  logic               blank3_s;
  logic               blank2_s;
  logic               blank1_s;
  logic [0:6]         seg3_s;
  logic [0:6]         seg2_s;
  logic [0:6]         seg1_s;
  logic [0:6]         seg0_s;

  // Widen the input to the 14-bit range and clip anything above 9999.
  always_comb begin
    value_ext_s              = 14'd0;
    value_ext_s[WIDTH-1:0]   = value;
    over_s                   = (value_ext_s > MAX_CODE);
    if (over_s) begin
      value_clip_s = MAX_CODE;
    end else begin
      value_clip_s = value_ext_s;
    end
  end

  // Add-3 correction of every accumulator nibble, all from pre-step values.
  always_comb begin
    acc_adj_s = 16'd0;
    for (int i = 0; i < 4; i++) begin
      if (acc_r[4*i +: 4] >= 4'd5) begin
        acc_adj_s[4*i +: 4] = acc_r[4*i +: 4] + 4'd3;
      end else begin
        acc_adj_s[4*i +: 4] = acc_r[4*i +: 4];
      end
    end
  end

  // Leading-zero blanking chain from the thousands digit down; units never blank.
  always_comb begin
    blank3_s = BLANK_LZ && (acc_r[15:12] == 4'd0);
    blank2_s = blank3_s && (acc_r[11:8] == 4'd0);
    blank1_s = blank2_s && (acc_r[7:4] == 4'd0);
  end

  seg7_decoder u_seg3 (.digit(acc_r[15:12]), .blank(blank3_s), .seg(seg3_s));
  seg7_decoder u_seg2 (.digit(acc_r[11:8]),  .blank(blank2_s), .seg(seg2_s));
  seg7_decoder u_seg1 (.digit(acc_r[7:4]),   .blank(blank1_s), .seg(seg1_s));
  seg7_decoder u_seg0 (.digit(acc_r[3:0]),   .blank(1'b0),     .seg(seg0_s));

  // Conversion FSM, double-dabble datapath and registered display outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      shift_r  <= '0;
      acc_r    <= 16'd0;
      cnt_r    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      bcd3     <= 4'd0;
      bcd2     <= 4'd0;
      bcd1     <= 4'd0;
      bcd0     <= 4'd0;
      HEX3     <= BLANK_LZ ? SEG_BLANK : seg_encode(4'd0);
      HEX2     <= BLANK_LZ ? SEG_BLANK : seg_encode(4'd0);
      HEX1     <= BLANK_LZ ? SEG_BLANK : seg_encode(4'd0);
      HEX0     <= seg_encode(4'd0);
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            shift_r  <= value_clip_s[WIDTH-1:0];
            overflow <= over_s;
            acc_r    <= 16'd0;
            cnt_r    <= CNT_W'(WIDTH);
            busy     <= 1'b1;
            state_r  <= SHIFT;
          end else begin
            state_r  <= IDLE;
          end
        end
        SHIFT: begin
          acc_r   <= {acc_adj_s[14:0], shift_r[WIDTH-1]};
          shift_r <= {shift_r[WIDTH-2:0], 1'b0};
          cnt_r   <= cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            state_r <= DONE;
          end else begin
            state_r <= SHIFT;
          end
        end
        DONE: begin
          bcd3    <= acc_r[15:12];
          bcd2    <= acc_r[11:8];
          bcd1    <= acc_r[7:4];
          bcd0    <= acc_r[3:0];
          HEX3    <= seg3_s;
          HEX2    <= seg2_s;
          HEX1    <= seg1_s;
          HEX0    <= seg0_s;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
